// File: rtl/conway_board_scanner.sv
// Snapshots the Conway board, streams it one row per valid/ready beat, then pulses step_ena once.
// Ports: clk, rst (async active-low), start, cells_q in; out_data/out_row/out_valid/out_last, out_ready in,
// busy, step_ena, frame_done out; CONWAY_SCAN_POPCOUNT_EN adds out_pop and frame_pop.
module conway_board_scanner #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1
`ifdef CONWAY_SCAN_POPCOUNT_EN
  ,
  localparam int PW = $clog2(COLS + 1),
  localparam int FW = $clog2(ROWS * COLS + 1)
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ROWS*COLS-1:0] cells_q,
  output logic [COLS-1:0]      out_data,
  output logic [RW-1:0]        out_row,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 step_ena,
`ifdef CONWAY_SCAN_POPCOUNT_EN
  output logic [PW-1:0]        out_pop,
  output logic [FW-1:0]        frame_pop,
`endif
  output logic                 frame_done
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    STEP
  } state_e;

  state_e               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [ROWS*COLS-1:0] snap_q, snap_d;
  logic [COLS-1:0]      row_word;
  logic                 last_row;

  assign last_row = (row_q == RW'(ROWS - 1));

  always_comb begin
    row_word = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (row_q == RW'(r)) row_word = snap_q[r*COLS +: COLS];
    end
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          snap_d  = cells_q;
          row_d   = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_row) begin
            row_d   = '0;
            state_d = STEP;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      STEP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      snap_q  <= snap_d;
    end
  end

  // Data is masked outside SEND so an idle link shows zeros.
  assign out_valid  = (state_q == SEND);
  assign out_data   = out_valid ? row_word : '0;
  assign out_row    = row_q;
  assign out_last   = out_valid & last_row;
  assign busy       = (state_q != IDLE);
  assign step_ena   = (state_q == STEP);
  assign frame_done = (state_q == STEP);

`ifdef CONWAY_SCAN_POPCOUNT_EN
  logic [FW-1:0] frame_pop_q, frame_pop_d;

  function automatic logic [PW-1:0] pop_row(input logic [COLS-1:0] w);
    logic [PW-1:0] n;
    n = '0;
    for (int i = 0; i < COLS; i++) n = n + PW'(w[i]);
    return n;
  endfunction

  function automatic logic [FW-1:0] pop_all(input logic [ROWS*COLS-1:0] w);
    logic [FW-1:0] n;
    n = '0;
    for (int i = 0; i < ROWS * COLS; i++) n = n + FW'(w[i]);
    return n;
  endfunction

  always_comb begin
    frame_pop_d = frame_pop_q;
    if (state_q == IDLE && start) frame_pop_d = pop_all(cells_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) frame_pop_q <= '0;
    else      frame_pop_q <= frame_pop_d;
  end

  assign out_pop   = pop_row(out_data);
  assign frame_pop = frame_pop_q;
`endif

endmodule

// File: tb/tb_conway_board_scanner.sv
// Directed bench for conway_board_scanner: 8x8 frames with stalls, ignored starts, abort,
// back-to-back frames, and a 1-row instance.
module tb_conway_board_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [63:0] cells_q = '0;
  logic [7:0]  out_data;
  logic [2:0]  out_row;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last;
  logic        busy;
  logic        step_ena;
  logic        frame_done;

  logic        start1 = 1'b0;
  logic [3:0]  cells1 = 4'b1011;
  logic [3:0]  out_data1;
  logic [0:0]  out_row1;
  logic        out_valid1;
  logic        out_ready1 = 1'b1;
  logic        out_last1;
  logic        busy1;
  logic        step_ena1;
  logic        frame_done1;

`ifdef CONWAY_SCAN_POPCOUNT_EN
  logic [3:0]  out_pop;
  logic [6:0]  frame_pop;
  logic [2:0]  out_pop1;
  logic [2:0]  frame_pop1;
`endif

  int n_vec = 0;
  int n_err = 0;

  localparam logic [63:0] PAT  = 64'h8142_2418_1824_4281;
  localparam logic [63:0] PAT2 = 64'h0123_4567_89ab_cdef;
  localparam logic [63:0] PAT3 = 64'hf00f_55aa_0ff0_a55a;

  always #5 clk = ~clk;

  conway_board_scanner #(.ROWS(8), .COLS(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .cells_q    (cells_q),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .busy       (busy),
    .step_ena   (step_ena),
`ifdef CONWAY_SCAN_POPCOUNT_EN
    .out_pop    (out_pop),
    .frame_pop  (frame_pop),
`endif
    .frame_done (frame_done)
  );

  conway_board_scanner #(.ROWS(1), .COLS(4)) dut1 (
    .clk        (clk),
    .rst        (rst),
    .start      (start1),
    .cells_q    (cells1),
    .out_data   (out_data1),
    .out_row    (out_row1),
    .out_valid  (out_valid1),
    .out_ready  (out_ready1),
    .out_last   (out_last1),
    .busy       (busy1),
    .step_ena   (step_ena1),
`ifdef CONWAY_SCAN_POPCOUNT_EN
    .out_pop    (out_pop1),
    .frame_pop  (frame_pop1),
`endif
    .frame_done (frame_done1)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered one cycle after start was sampled; leaves in the IDLE cycle after STEP.
  task automatic run_frame(input logic [63:0] exp, input int stall_at,
                           input logic [7:0] pulse, input logic pulse_step);
    for (int r = 0; r < 8; r++) begin
      chk($sformatf("valid r%0d", r), out_valid, 1'b1);
      chk($sformatf("row r%0d", r), out_row, r[2:0]);
      chk($sformatf("data r%0d", r), out_data, exp[r*8 +: 8]);
      chk($sformatf("last r%0d", r), out_last, r == 7);
      chk($sformatf("step r%0d", r), step_ena, 1'b0);
`ifdef CONWAY_SCAN_POPCOUNT_EN
      chk($sformatf("pop r%0d", r), out_pop, $countones(exp[r*8 +: 8]));
`endif
      if (r == stall_at) begin
        out_ready = 1'b0;
        cells_q   = '1;
        for (int s = 0; s < 5; s++) begin
          tick();
          chk("stall valid", out_valid, 1'b1);
          chk("stall data", out_data, exp[r*8 +: 8]);
          chk("stall row", out_row, r[2:0]);
          chk("stall step", step_ena, 1'b0);
        end
        out_ready = 1'b1;
      end
      start = pulse[r];
      tick();
    end
    chk("step_ena", step_ena, 1'b1);
    chk("frame_done", frame_done, 1'b1);
    chk("step busy", busy, 1'b1);
    chk("step valid", out_valid, 1'b0);
    start = pulse_step;
    tick();
    chk("post step", step_ena, 1'b0);
    chk("post done", frame_done, 1'b0);
    chk("post busy", busy, 1'b0);
    chk("post valid", out_valid, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst valid", out_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
`ifdef CONWAY_SCAN_POPCOUNT_EN
    chk("rst frame_pop", frame_pop, 7'd0);
`endif
    tick();
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle", {out_valid, busy, step_ena, frame_done, out_data},
          12'h000);
    end

    // Plain frame
    cells_q = PAT;
    start = 1'b1;
    tick();
    start = 1'b0;
`ifdef CONWAY_SCAN_POPCOUNT_EN
    chk("frame_pop", frame_pop, 7'd16);
`endif
    run_frame(PAT, -1, 8'h00, 1'b0);

    // Stall at row 3 while the board changes underneath
    cells_q = PAT2;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(PAT2, 3, 8'h00, 1'b0);

    // Starts during rows 2, 5 and STEP are dropped
    cells_q = PAT;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(PAT, -1, 8'b0010_0100, 1'b1);
    start = 1'b0;
    tick();
    chk("ignored idle valid", out_valid, 1'b0);
    chk("ignored idle busy", busy, 1'b0);

    // Abort mid-frame after four beats
    cells_q = PAT2;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    chk("pre-abort row", out_row, 3'd4);
    rst = 1'b0;
    #1;
    chk("abort valid", out_valid, 1'b0);
    chk("abort busy", busy, 1'b0);
    chk("abort data", out_data, 8'h00);
    chk("abort row", out_row, 3'd0);
    tick();
    chk("abort step", step_ena, 1'b0);
    rst = 1'b1;
    tick();
    chk("after abort valid", out_valid, 1'b0);
    chk("after abort step", step_ena, 1'b0);
    cells_q = PAT3;
    start = 1'b1;
    tick();
    start = 1'b0;
    run_frame(PAT3, -1, 8'h00, 1'b0);

    // Held start: frames every ROWS+2 cycles, each snapshotting the new board
    cells_q = PAT;
    start = 1'b1;
    tick();
    cells_q = PAT2;
    run_frame(PAT, -1, 8'hff, 1'b1);
    tick();
    cells_q = PAT3;
    run_frame(PAT2, -1, 8'hff, 1'b0);

    // Single-row board
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    chk("r1 valid", out_valid1, 1'b1);
    chk("r1 last", out_last1, 1'b1);
    chk("r1 row", out_row1, 1'b0);
    chk("r1 data", out_data1, 4'hb);
`ifdef CONWAY_SCAN_POPCOUNT_EN
    chk("r1 pop", out_pop1, 3'd3);
    chk("r1 frame_pop", frame_pop1, 3'd3);
`endif
    tick();
    chk("r1 step", {step_ena1, frame_done1, out_valid1, out_row1}, 4'b1100);
    tick();
    chk("r1 idle", {step_ena1, busy1, out_valid1}, 3'b000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/conway_board_scanner.md
Name: conway_board_scanner

Overview:
- Read-side companion to the Conway cell array. The cells write their next state each generation; this block reads it.
- On a start request it snapshots the flattened board state (every cell's state_q).
- It streams the snapshot out one row per valid/ready beat, for a display or host link.
- After the last row it issues a one-cycle ena pulse that advances the cell array by exactly one generation.

Parameters:
- ROWS, 8, number of board rows.
- COLS, 8, number of board columns; also the output word width.
- RW, $clog2(ROWS) (min 1), row index width; derived, not overridden.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- start  in  1  frame request; sampled only in IDLE.
- cells_q  in  ROWS*COLS  board state; cell (r,c) = bit r*COLS+c.
- out_data  out  COLS  row word; bit c = column c.
- out_row  out  RW  row index of current beat.
- out_valid  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_last  out  1  high with the beat for row ROWS-1.
- busy  out  1  high in SEND or STEP.
- step_ena  out  1  one-cycle generation-advance pulse to the cell array's ena.
- frame_done  out  1  one-cycle pulse, coincident with step_ena.

Behaviour:
- Reset (rst=0, async): state=IDLE; snapshot, row counter and all outputs are 0. Deassertion is synchronous to clk.
- States: IDLE, SEND, STEP.
- IDLE:
  - busy=0, out_valid=0.
  - Edge with start=1: load snapshot<=cells_q, row<=0, go SEND.
  - out_valid is high in the cycle immediately after start is sampled.
- SEND:
  - out_valid=1, out_row=row, out_data=snapshot[row*COLS +: COLS].
  - out_last=(row==ROWS-1).
  - All outputs are registered or derived only from registered state. No combinational path from out_ready to outputs.
  - Beat transfers on an edge with out_valid & out_ready.
  - Transfer with row<ROWS-1: row<=row+1.
  - Transfer with row==ROWS-1: row<=0, go STEP.
  - With out_ready=0, out_data, out_row and out_last hold stable; a stall of any length is legal.
  - Changes to cells_q during SEND do not affect the frame; only the snapshot is emitted.
- STEP:
  - Exactly one cycle: step_ena=1, frame_done=1, busy=1, out_valid=0. Then go IDLE.
- start in SEND or STEP is ignored, not queued.
- start held high continuously gives back-to-back frames. Each frame costs ROWS beats + 1 STEP cycle + 1 IDLE cycle with zero stall. Successive snapshots see successive generations.
- ROWS=1: the single beat carries out_last=1; the row counter stays 0.
- rst asserted mid-frame: frame aborted immediately, no step_ena issued, IDLE on release.
- Row counter never exceeds ROWS-1, including for non-power-of-two ROWS.

Optional Feature:
- Macro: CONWAY_SCAN_POPCOUNT_EN.
- Defined:
  - Adds output out_pop, width $clog2(COLS+1): the live-cell count of the current out_data, valid whenever out_valid=1.
  - Adds output frame_pop, width $clog2(ROWS*COLS+1): the total live cells of the snapshot.
  - frame_pop is computed at snapshot load and held until the next snapshot. It reads 0 after reset.
  - Both outputs are registered or derived from the snapshot only, with no added latency to the stream.
- Undefined: neither port exists; all other behaviour is identical.

Test Plan:
- Reset, idle: rst=0 then 1, no start, 20 cycles -> out_valid, busy, step_ena, frame_done and out_data all 0 throughout.
- Single frame, ready=1, 8x8, cells_q=64'h8142_2418_1824_4281:
  - out_valid rises the cycle after start.
  - 8 consecutive beats: row0=8'h81, row1=8'h42, row2=8'h24, row3=8'h18, row4=8'h18, row5=8'h24, row6=8'h42, row7=8'h81.
  - out_last only on row 7.
  - Next cycle: step_ena=1 and frame_done=1 for exactly 1 cycle.
- Backpressure: out_ready=0 for 5 cycles at row 3, and cells_q changed to all-ones during the stall -> row 3 data held unchanged, total beats=8, step_ena delayed by 5 cycles, emitted data equals the original snapshot.
- Ignored start: start pulsed at rows 2 and 5 and during STEP -> exactly one frame and one step_ena; IDLE afterwards.
- Reset mid-frame: rst=0 for 1 cycle after beat 4 -> outputs 0 immediately, no step_ena, next start emits a fresh 8-beat frame from row 0.
- POPCOUNT_EN build, cells_q=64'h8142_2418_1824_4281 -> out_pop=2 on every row, frame_pop=16. Non-EN build compiles without these ports.
